// File: rtl/unary_dot_pkg.sv
// rtl/unary_dot_pkg.sv - shared state type, result sizing and popcount for the unary dot engine
package unary_dot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest lane vector the popcount helper handles; LANES must not exceed it.
  localparam int POP_MAX = 64;

  // Full product width plus enough headroom to sum every lane without overflow.
  function automatic int acc_width(input int width, input int lanes);
    return 2 * width + $clog2(lanes);
  endfunction

  // Number of set bits; narrower lane vectors are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/unary_lane.sv
// rtl/unary_lane.sv - one product lane emitting |w|*|x| back-to-back pulses (sign flag under UNARY_DOT_SIGNED_EN)
module unary_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] x,
  output logic             pulse,
  output logic             last
`ifdef UNARY_DOT_SIGNED_EN
  ,
  output logic             neg
`endif
);

  logic [WIDTH-1:0] outer;
  logic [WIDTH-1:0] inner;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] x_mag;

`ifdef UNARY_DOT_SIGNED_EN
  // Two's complement magnitude; the most-negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit count.
  assign w_mag = w[WIDTH-1] ? ((~w) + WIDTH'(1)) : w;
  assign x_mag = x[WIDTH-1] ? ((~x) + WIDTH'(1)) : x;
`else
  assign w_mag = w;
  assign x_mag = x;
`endif

  // A lane with either counter at zero is idle; zero operands and disabled
  // lanes are loaded as all-zero so they never pulse.
  assign pulse = (outer != '0) && (inner != '0);
  assign last  = pulse && (inner == WIDTH'(1)) && (outer == WIDTH'(1));

  // Outer counts rows of |x| pulses; the inner reload on the last pulse of a
  // row keeps the stream free of bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outer  <= '0;
      inner  <= '0;
      reload <= '0;
    end else if (load) begin
      if (en && (w_mag != '0) && (x_mag != '0)) begin
        outer  <= w_mag;
        inner  <= x_mag;
        reload <= x_mag;
      end else begin
        outer  <= '0;
        inner  <= '0;
        reload <= '0;
      end
    end else if (pulse) begin
      if (inner == WIDTH'(1)) begin
        if (outer == WIDTH'(1)) begin
          outer <= '0;
          inner <= '0;
        end else begin
          outer <= outer - WIDTH'(1);
          inner <= reload;
        end
      end else begin
        inner <= inner - WIDTH'(1);
      end
    end
  end

`ifdef UNARY_DOT_SIGNED_EN
  // Product sign is captured once per job; it only matters while pulsing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg <= 1'b0;
    end else if (load) begin
      neg <= w[WIDTH-1] ^ x[WIDTH-1];
    end
  end
`endif

endmodule

// File: rtl/unary_dot_engine.sv
// rtl/unary_dot_engine.sv - unary dot-product engine top: FSM, handshakes, popcount accumulator (signed mode: UNARY_DOT_SIGNED_EN)
module unary_dot_engine
  import unary_dot_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LANES = 16,
  parameter int ACC_W = acc_width(WIDTH, LANES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] w,
  input  logic [LANES*WIDTH-1:0] x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       result
);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             more_work;
  logic [LANES-1:0] pulse_vec;
  logic [LANES-1:0] last_vec;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_delta;
`ifdef UNARY_DOT_SIGNED_EN
  logic [LANES-1:0] neg_vec;
  logic [ACC_W-1:0] pos_cnt;
  logic [ACC_W-1:0] neg_cnt;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    unary_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (accept),
      .en     (lane_en[i]),
      .w      (w[i*WIDTH +: WIDTH]),
      .x      (x[i*WIDTH +: WIDTH]),
      .pulse  (pulse_vec[i]),
      .last   (last_vec[i])
`ifdef UNARY_DOT_SIGNED_EN
      ,
      .neg    (neg_vec[i])
`endif
    );
  end

  // Some lane is still pulsing after this cycle, so RUN must continue.
  assign more_work = |(pulse_vec & ~last_vec);

`ifdef UNARY_DOT_SIGNED_EN
  assign pos_cnt   = ACC_W'(popcount(POP_MAX'(pulse_vec & ~neg_vec)));
  assign neg_cnt   = ACC_W'(popcount(POP_MAX'(pulse_vec & neg_vec)));
  assign acc_delta = pos_cnt - neg_cnt;
`else
  assign acc_delta = ACC_W'(popcount(POP_MAX'(pulse_vec)));
`endif

  assign result = acc_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshakes; DONE can consume and accept on the same edge.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!more_work) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = in_valid ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    accept = in_valid && in_ready;
  end

  // Accumulator clears on accept and sums lane pulses only while running,
  // so the result is frozen throughout DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_q + acc_delta;
    end
  end

endmodule

// File: tb/tb_unary_dot_engine.sv
// tb/tb_unary_dot_engine.sv - randomized self-checking bench for unary_dot_engine against an arithmetic model
module tb_unary_dot_engine;

  localparam int WIDTH = 4;
  localparam int LANES = 16;
  localparam int ACC_W = 2 * WIDTH + $clog2(LANES);

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANES-1:0]       lane_en = '0;
  logic [LANES*WIDTH-1:0] w = '0;
  logic [LANES*WIDTH-1:0] x = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [ACC_W-1:0]       result;

  logic [WIDTH-1:0] wa[LANES];
  logic [WIDTH-1:0] xa[LANES];
  logic [LANES-1:0] ena;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  unary_dot_engine #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .ACC_W(ACC_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .lane_en  (lane_en),
    .w        (w),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_ops();
    for (int i = 0; i < LANES; i++) begin
      wa[i] = '0;
      xa[i] = '0;
    end
    ena = '1;
  endtask

  task automatic apply_ops();
    for (int i = 0; i < LANES; i++) begin
      w[i*WIDTH +: WIDTH] = wa[i];
      x[i*WIDTH +: WIDTH] = xa[i];
    end
    lane_en = ena;
  endtask

  // Dot product of the enabled lanes and the longest lane stream length.
  task automatic model(output logic [ACC_W-1:0] exp_res, output int exp_n);
    longint sum;
    int a;
    int b;
    int p;
    sum = 0;
    exp_n = 1;
    for (int i = 0; i < LANES; i++) begin
      if (ena[i]) begin
`ifdef UNARY_DOT_SIGNED_EN
        a = int'($signed(wa[i]));
        b = int'($signed(xa[i]));
`else
        a = int'(wa[i]);
        b = int'(xa[i]);
`endif
        p = a * b;
        sum = sum + longint'(p);
        if (p < 0) p = -p;
        if (p > exp_n) exp_n = p;
      end
    end
    exp_res = ACC_W'(sum);
  endtask

  task automatic accept_job(input string tag);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({tag, "_acc_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called at #1 after the accept edge; latency counts that edge as 1.
  task automatic wait_done(input string tag, input logic [ACC_W-1:0] exp_res, input int exp_n);
    int lat;
    lat = 1;
    check({tag, "_rdy_run"}, 64'(in_ready), 64'd0);
    while (!out_valid && lat < exp_n + 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_n + 1));
    check({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, 64'(result), 64'(exp_res));
  endtask

  task automatic consume(input string tag, input int hold);
    logic [ACC_W-1:0] held;
    held = result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_res"}, 64'(result), 64'(held));
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_job(input string tag, input int hold);
    logic [ACC_W-1:0] er;
    int en_cycles;
    apply_ops();
    model(er, en_cycles);
    accept_job(tag);
    wait_done(tag, er, en_cycles);
    consume(tag, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] er;
    int en_cycles;
    logic seen;

    clear_ops();
    apply_ops();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_irdy", 64'(in_ready), 64'd1);
    check("rst_res", 64'(result), 64'd0);

    // Single lane 3x2 with the rest zero.
    clear_ops();
    wa[0] = 4'd3; xa[0] = 4'd2;
    run_job("l0_3x2", 0);

    // Every lane at full scale.
    clear_ops();
    for (int i = 0; i < LANES; i++) begin
      wa[i] = 4'd15; xa[i] = 4'd15;
    end
    run_job("full", 1);

    // All zero operands, then a disabled non-zero lane.
    clear_ops();
    run_job("zero", 0);
    clear_ops();
    wa[0] = 4'd5; xa[0] = 4'd4; ena[0] = 1'b0;
    run_job("dis", 0);

    // Backpressure in DONE, then consume and accept on the same edge.
    clear_ops();
    wa[0] = 4'd5; xa[0] = 4'd3;
    apply_ops();
    model(er, en_cycles);
    accept_job("bp");
    wait_done("bp", er, en_cycles);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_res", 64'(result), 64'(er));
      check("bp_rdy", 64'(in_ready), 64'd0);
      check("bp_ovalid", 64'(out_valid), 64'd1);
    end
    clear_ops();
    wa[0] = 4'd2; xa[0] = 4'd2;
    apply_ops();
    model(er, en_cycles);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_rdy", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_ovalid", 64'(out_valid), 64'd0);
    wait_done("b2b", er, en_cycles);
    consume("b2b", 0);

    // Reset in RUN cycle 3 discards the job.
    clear_ops();
    wa[0] = 4'd7; xa[0] = 4'd7;
    apply_ops();
    accept_job("abort");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_ovalid", 64'(out_valid), 64'd0);
    check("abort_irdy", 64'(in_ready), 64'd1);
    check("abort_res", 64'(result), 64'd0);
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("abort_no_out", 64'(seen), 64'd0);
    clear_ops();
    wa[0] = 4'd1; xa[0] = 4'd1;
    run_job("post_rst", 0);

`ifdef UNARY_DOT_SIGNED_EN
    clear_ops();
    wa[0] = 4'hD; xa[0] = 4'd2;
    wa[1] = 4'd4; xa[1] = 4'd1;
    apply_ops();
    accept_job("sgn_mix");
    wait_done("sgn_mix", 12'hFFE, 6);
    consume("sgn_mix", 0);
    clear_ops();
    wa[0] = 4'h8; xa[0] = 4'h8;
    apply_ops();
    accept_job("sgn_min");
    wait_done("sgn_min", 12'd64, 64);
    consume("sgn_min", 0);
`endif

    // Random operand sets, mostly short streams with occasional full range.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          wa[i] = WIDTH'($urandom_range(0, 15));
          xa[i] = WIDTH'($urandom_range(0, 15));
        end else begin
          wa[i] = WIDTH'($urandom_range(0, 3));
          xa[i] = WIDTH'($urandom_range(0, 3));
        end
      end
      ena = LANES'($urandom);
      run_job("rnd", int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unary_dot_engine.md
# unary_dot_engine

Parametrised unary (pulse-stream) dot-product engine for the stochastic-compute datapath. It accepts LANES pairs of WIDTH-bit operands through a valid/ready handshake. Each lane emits exactly w·x consecutive one-pulses. A per-cycle popcount of all lanes is accumulated into a single binary result, which is held under an output valid/ready handshake. It supersedes the fixed 4-bit/16-lane product-block plus adder-tree arrangement and adds:
- a registered accumulator
- bubble-free lane streams
- correct zero-operand handling
- lane enables
- optional signed operation

## Interface
Parameters:
- WIDTH, 4, operand width per lane
- LANES, 16, number of product lanes
- ACC_W, 2*WIDTH+$clog2(LANES), accumulator/result width

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand set valid
- in_ready  output  1  engine can accept an operand set
- lane_en  input  LANES  per-lane enable, sampled at accept
- w  input  LANES×WIDTH  weight operands, sampled at accept
- x  input  LANES×WIDTH  activation operands, sampled at accept
- out_valid  output  1  result valid
- out_ready  input  1  downstream consumes result
- result  output  ACC_W  accumulated dot product

## Operation
- States:
  - IDLE: waiting for an operand set.
  - RUN: lanes streaming, accumulator updating.
  - DONE: result held.
- Accept occurs when in_valid && in_ready at a rising edge. in_ready = (state==IDLE) || (state==DONE && out_ready).
- On accept:
  - Each lane loads an outer counter with |w| and an inner counter with |x|, and saves |x| as its reload value.
  - The accumulator clears to 0.
  - State → RUN.
- Lane output is 1 while the lane is busy. A lane is busy iff lane_en was 1 at accept, w≠0, x≠0, and its counters are not exhausted.
- Each busy cycle, the inner counter decrements. When inner==1 and outer>1, inner reloads to |x| and outer decrements in the same cycle, so there is no idle cycle between rows. When inner==1 and outer==1, the lane goes idle.
- A lane emits exactly |w|·|x| pulses. A zero operand or disabled lane emits none.
- In RUN, each cycle: acc ← acc + popcount(lane outputs).
- RUN lasts N = max(1, max over lanes of |w|·|x|) cycles. RUN → DONE after the cycle in which no lane remains busy.
- DONE: out_valid=1 and result=acc.
  - out_ready && !in_valid → IDLE.
  - out_ready && in_valid → accept the new set directly into RUN (back-to-back).
  - !out_ready → remain in DONE with result stable.
- ACC_W is sized so the accumulator cannot overflow; no saturation logic is required.

## Timing
- Reset values: state IDLE, acc 0, all lane counters 0, out_valid 0, result 0, in_ready 1.
- Latency: out_valid rises N+1 cycles after the accept cycle. For w=3, x=2 on a single lane: RUN cycles 1–6, out_valid in cycle 7.
- result changes only during RUN. It is stable through DONE until the consume edge.
- Reset asserted mid-RUN or mid-DONE:
  - Aborts immediately to reset values.
  - The job is discarded.
  - No out_valid is produced for it.
- in_valid during RUN is ignored; in_ready=0 during RUN.

## Configuration
- UNARY_DOT_SIGNED_EN defined:
  - w and x are two's complement.
  - Lanes stream magnitudes. Each lane's sign = sign(w) XOR sign(x).
  - Each cycle: acc ← acc + popcount(positive-lane pulses) − popcount(negative-lane pulses).
  - result is two's complement.
  - Magnitude of the most-negative value (2^(WIDTH−1)) is handled exactly.
- Undefined: operands are unsigned and acc is only incremented. No sign logic is synthesised.

## Structure
- Package unary_dot_pkg:
  - state enum (IDLE, RUN, DONE)
  - function computing the default ACC_W
  - popcount function over a LANES-wide vector
- Sub-module unary_lane:
  - load / busy / pulse interface
  - outer, inner, and reload counters
  - sign flag under UNARY_DOT_SIGNED_EN
- Instantiated LANES times via generate.
- The top holds the FSM, handshakes, popcount, and accumulator.

## Test plan
- Lane0 w=3 x=2, all other lanes 0, all lanes enabled → result 6, out_valid 7 cycles after accept.
- All 16 lanes w=15 x=15 → result 3600, RUN exactly 225 cycles, no overflow.
- All operands 0 → RUN 1 cycle, result 0, out_valid 2 cycles after accept. Lane0 w=5 x=4 with lane_en[0]=0 → result 0.
- out_ready held low 5 cycles in DONE → result stable, in_ready 0. Then out_ready=1 with in_valid=1 carrying lane0 w=2 x=2 → same-edge consume and accept, next result 4.
- reset_n pulsed low in RUN cycle 3 of a w=7 x=7 job → out_valid 0, in_ready 1 after release. Next job lane0 w=1 x=1 → result 1.
- With UNARY_DOT_SIGNED_EN: lane0 w=−3 x=2, lane1 w=4 x=1 → result −2 (all ones in the upper bits), RUN 6 cycles. Lane0 w=−8 x=−8 (WIDTH=4) → 64.
